// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with fetch/execute handshake
//
// Steps instructions through FETCH (request to instruction memory until
// acked) and EXEC (one or more cycles, held by stall). The PC updates on
// the EXEC edge with stall low. Next-PC priority: trap > jump > branch >
// sequential. All address arithmetic wraps modulo 2^32.
//
// Optional feature macro: PC_TRAP_VECTOR_EN. When it is defined, the
// TRAP_ADDR parameter and the trap/epc ports exist.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   imem_req      fetch request (high in FETCH)
//   imem_addr     fetch address, equal to pc_out
//   imem_ack      fetch complete (used only in FETCH)
//   instr_valid   instruction executing (high in EXEC)
//   stall         hold current instruction in EXEC
//   branch_taken  take branch to pc_plus4 + (branch_offset << 2)
//   branch_offset sign-extended word offset
//   jump          take jump to {pc_plus4[31:28], jump_target, 2'b00}
//   jump_target   jump word index
//   halt          enter HALTED after the current instruction
//   pc_out        current PC
//   pc_plus4      pc_out + 4
//   trap          exception request (macro only)
//   epc           PC of trapping instruction (macro only)
module pc_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
`ifdef PC_TRAP_VECTOR_EN
    ,
    parameter logic [31:0] TRAP_ADDR  = 32'h0000_0080
`endif
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        halt,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
`ifdef PC_TRAP_VECTOR_EN
    ,
    input  logic        trap,
    output logic [31:0] epc
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_pc;

`ifdef PC_TRAP_VECTOR_EN
    logic [31:0] epc_q, epc_d;
`endif

    assign pc_plus4 = pc_q + 32'd4;

    // Target chosen by the non-trap redirect rules; trap overrides below.
    always_comb begin
        redirect_pc = pc_plus4;
        if (jump) begin
            redirect_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            redirect_pc = pc_plus4 + (branch_offset << 2);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_TRAP_VECTOR_EN
        epc_d   = epc_q;
`endif
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  if (imem_ack) state_d = EXEC;
            EXEC: begin
                if (!stall) begin
                    pc_d    = redirect_pc;
                    state_d = halt ? HALTED : FETCH;
`ifdef PC_TRAP_VECTOR_EN
                    // Trap wins over every redirect and cancels halt.
                    if (trap) begin
                        pc_d    = TRAP_ADDR;
                        epc_d   = pc_q;
                        state_d = FETCH;
                    end
`endif
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_ADDR;
`ifdef PC_TRAP_VECTOR_EN
            epc_q   <= 32'h0000_0000;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef PC_TRAP_VECTOR_EN
            epc_q   <= epc_d;
`endif
        end
    end

    // Decoded straight from the state register so reset clears them at once.
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign pc_out      = pc_q;
    assign imem_addr   = pc_q;
`ifdef PC_TRAP_VECTOR_EN
    assign epc         = epc_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] TRAP_ADDR  = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        halt;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
`ifdef PC_TRAP_VECTOR_EN
    logic        trap;
    logic [31:0] epc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_ADDR(RESET_ADDR)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4)
`ifdef PC_TRAP_VECTOR_EN
        ,
        .trap          (trap),
        .epc           (epc)
`endif
    );

    task automatic clear_inputs();
        imem_ack      = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 32'h0;
        jump          = 1'b0;
        jump_target   = 26'h0;
        halt          = 1'b0;
`ifdef PC_TRAP_VECTOR_EN
        trap          = 1'b0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT just out of reset (IDLE), at a falling edge.
    task automatic apply_reset();
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Acks the fetch, then presents the given controls for one EXEC edge.
    task automatic exec_instr(input logic br, input logic [31:0] off,
                              input logic j, input logic [25:0] tgt,
                              input logic h);
        int n = 0;
        imem_ack = 1'b1;
        while (instr_valid !== 1'b1 && n < 6) begin
            tick();
            n++;
        end
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL exec_wait: instr_valid=%b required 1", instr_valid);
        end
        branch_taken  = br;
        branch_offset = off;
        jump          = j;
        jump_target   = tgt;
        halt          = h;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        #2;
        checks++;
        if (pc_out !== RESET_ADDR || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h req=%b valid=%b required pc=%h req=0 valid=0",
                     pc_out, imem_req, instr_valid, RESET_ADDR);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL idle_to_fetch: req=%b required 1", imem_req);
        end
        exec_instr(0, 0, 0, 0, 0);
        exec_instr(0, 0, 0, 0, 0);
        imem_ack = 1'b1;
        tick();
        // Mid-EXEC at pc 8: reset must act without a clock edge.
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (pc_out !== RESET_ADDR || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_exec: pc=%h valid=%b req=%b required pc=%h valid=0 req=0",
                     pc_out, instr_valid, imem_req, RESET_ADDR);
        end
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc_out !== RESET_ADDR) begin
            errors++;
            $display("FAIL reset_mid_fetch: req=%b pc=%h required req=0 pc=%h",
                     imem_req, pc_out, RESET_ADDR);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || pc_out !== RESET_ADDR) begin
            errors++;
            $display("FAIL reset_release: req=%b pc=%h required req=1 pc=%h",
                     imem_req, pc_out, RESET_ADDR);
        end
    endtask

    task automatic test_sequential();
        apply_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || instr_valid !== 1'b0 ||
                pc_out !== 32'(4 * k) || imem_addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: req=%b valid=%b pc=%h addr=%h required req=1 valid=0 pc=%h",
                         k, imem_req, instr_valid, pc_out, imem_addr, 32'(4 * k));
            end
            tick();
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b1 ||
                pc_out !== 32'(4 * k) || pc_plus4 !== 32'(4 * k + 4)) begin
                errors++;
                $display("FAIL seq_exec[%0d]: req=%b valid=%b pc=%h pc4=%h required req=0 valid=1 pc=%h",
                         k, imem_req, instr_valid, pc_out, pc_plus4, 32'(4 * k));
            end
        end
        tick();
        checks++;
        if (pc_out !== 32'h10) begin
            errors++;
            $display("FAIL seq_final: pc=%h required 00000010", pc_out);
        end
        clear_inputs();
    endtask

    task automatic test_branch_jump();
        apply_reset();
        tick();
        exec_instr(0, 0, 1, 26'h10, 0);
        checks++;
        if (pc_out !== 32'h40) begin
            errors++;
            $display("FAIL jump_to_40: pc=%h required 00000040", pc_out);
        end
        exec_instr(1, 32'hFFFF_FFFE, 0, 0, 0);
        checks++;
        if (pc_out !== 32'h3C || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL branch_back: pc=%h req=%b required pc=0000003c req=1", pc_out, imem_req);
        end
        exec_instr(0, 0, 1, 26'h10, 0);
        exec_instr(1, 32'hFFFF_FFFE, 1, 26'h123, 0);
        checks++;
        if (pc_out !== 32'h48C) begin
            errors++;
            $display("FAIL jump_over_branch: pc=%h required 0000048c", pc_out);
        end
    endtask

    task automatic test_wait_stall();
        int req_cnt = 0;
        int val_cnt = 0;
        int pc_bad = 0;
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            tick();
            if (imem_req === 1'b1) req_cnt++;
            if (instr_valid === 1'b1) val_cnt++;
            if (pc_out !== 32'h0) pc_bad++;
            imem_ack = (req_cnt >= 4);
            // Redirect/halt requests while stalled must be ignored.
            stall    = (val_cnt < 3);
            jump     = (val_cnt < 3);
            halt     = (val_cnt < 3);
            jump_target = 26'h3FF_FFFF;
        end
        checks++;
        if (req_cnt != 4 || val_cnt != 3 || pc_bad != 0) begin
            errors++;
            $display("FAIL wait_stall_counts: req=%0d valid=%0d pc_changes=%0d required 4 3 0",
                     req_cnt, val_cnt, pc_bad);
        end
        tick();
        checks++;
        if (pc_out !== 32'h4 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL wait_stall_after: pc=%h req=%b required pc=00000004 req=1", pc_out, imem_req);
        end
        clear_inputs();
    endtask

    task automatic test_wrap_halt();
        apply_reset();
        tick();
        exec_instr(0, 0, 1, 26'h10, 0);
        exec_instr(1, 32'hFFFF_FFEE, 0, 0, 0);
        checks++;
        if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL reach_top: pc=%h pc4=%h required pc=fffffffc pc4=00000000", pc_out, pc_plus4);
        end
        exec_instr(0, 0, 0, 0, 0);
        checks++;
        if (pc_out !== 32'h0) begin
            errors++;
            $display("FAIL wrap: pc=%h required 00000000", pc_out);
        end
        exec_instr(0, 0, 1, 26'h20, 1);
        checks++;
        if (pc_out !== 32'h80 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_jump: pc=%h req=%b valid=%b required pc=00000080 req=0 valid=0",
                     pc_out, imem_req, instr_valid);
        end
        for (int c = 0; c < 5; c++) begin
            imem_ack     = 1'b1;
            jump         = 1'(($urandom % 2));
            branch_taken = 1'(($urandom % 2));
            jump_target  = 26'($urandom);
            tick();
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_out !== 32'h80) begin
                errors++;
                $display("FAIL halted_hold[%0d]: req=%b valid=%b pc=%h required req=0 valid=0 pc=00000080",
                         c, imem_req, instr_valid, pc_out);
            end
        end
        clear_inputs();
    endtask

`ifdef PC_TRAP_VECTOR_EN
    task automatic test_trap();
        apply_reset();
        for (int k = 0; k < 4; k++) exec_instr(0, 0, 0, 0, 0);
        checks++;
        if (pc_out !== 32'h10) begin
            errors++;
            $display("FAIL trap_setup: pc=%h required 00000010", pc_out);
        end
        imem_ack = 1'b1;
        tick();
        trap = 1'b1;
        halt = 1'b1;
        jump = 1'b1;
        jump_target = 26'h55;
        tick();
        checks++;
        if (pc_out !== TRAP_ADDR || epc !== 32'h10 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL trap: pc=%h epc=%h req=%b required pc=%h epc=00000010 req=1",
                     pc_out, epc, imem_req, TRAP_ADDR);
        end
        clear_inputs();
    endtask
`endif

    // Reference: one instruction is "fetch until acked, execute until not
    // stalled, then retarget"; the model tracks the phase as a small integer.
    task automatic test_random();
        logic [31:0] m_pc;
        logic [31:0] m_epc;
        int m_phase;
        logic t;
        apply_reset();
        m_pc = RESET_ADDR;
        m_epc = 32'h0;
        m_phase = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            imem_ack      = (($urandom % 4) != 0);
            stall         = (($urandom % 4) == 0);
            branch_taken  = 1'(($urandom % 2));
            branch_offset = ($urandom % 2) ? $urandom : (32'($urandom_range(0, 63)) - 32'd32);
            jump          = (($urandom % 5) == 0);
            jump_target   = 26'($urandom);
            halt          = (($urandom % 25) == 0);
            t = 1'b0;
`ifdef PC_TRAP_VECTOR_EN
            trap = (($urandom % 8) == 0);
            t    = trap;
`endif
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (imem_ack) m_phase = 2;
            end else if (m_phase == 2 && !stall) begin
                if (t) begin
                    m_epc = m_pc;
                    m_pc = TRAP_ADDR;
                    m_phase = 1;
                end else begin
                    if (jump)
                        m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'b0, jump_target} * 32'd4);
                    else if (branch_taken)
                        m_pc = m_pc + 32'd4 + branch_offset * 32'd4;
                    else
                        m_pc = m_pc + 32'd4;
                    m_phase = halt ? 3 : 1;
                end
            end
            tick();
            checks++;
            if (pc_out !== m_pc || imem_addr !== m_pc || pc_plus4 !== (m_pc + 32'd4) ||
                imem_req !== (m_phase == 1) || instr_valid !== (m_phase == 2)
`ifdef PC_TRAP_VECTOR_EN
                || epc !== m_epc
`endif
                ) begin
                errors++;
                $display("FAIL random[%0d]: pc=%h req=%b valid=%b required pc=%h req=%b valid=%b",
                         cyc, pc_out, imem_req, instr_valid, m_pc, (m_phase == 1), (m_phase == 2));
            end
            if (m_phase == 3 && ($urandom % 4) == 0) begin
                apply_reset();
                m_pc = RESET_ADDR;
                m_epc = 32'h0;
                m_phase = 0;
            end
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch_jump();
        test_wait_stall();
        test_wrap_halt();
`ifdef PC_TRAP_VECTOR_EN
        test_trap();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TRAP_ADDR, default 32'h0000_0080, trap vector address (used only with PC_TRAP_VECTOR_EN).
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address; equals pc_out.
REQ-007 imem_ack  input  1  instruction memory completed fetch this cycle.
REQ-008 instr_valid  output  1  fetched instruction is being executed this cycle.
REQ-009 stall  input  1  datapath requests hold of current instruction.
REQ-010 branch_taken  input  1  take conditional branch.
REQ-011 branch_offset  input  32  sign-extended word offset.
REQ-012 jump  input  1  take absolute jump.
REQ-013 jump_target  input  26  jump word index.
REQ-014 halt  input  1  stop fetching after current instruction.
REQ-015 pc_out  output  32  current PC.
REQ-016 pc_plus4  output  32  pc_out + 4, combinational.
REQ-017 trap  input  1  exception request (present only with PC_TRAP_VECTOR_EN).
REQ-018 epc  output  32  PC of trapping instruction (present only with PC_TRAP_VECTOR_EN).

Function
REQ-019 FSM states SHALL be IDLE, FETCH, EXEC, HALTED; IDLE moves to FETCH unconditionally one cycle after reset release.
REQ-020 In FETCH, imem_req SHALL be 1; imem_ack=1 moves to EXEC on the next edge, otherwise the FSM stays in FETCH.
REQ-021 In EXEC, instr_valid SHALL be 1; stall=1 keeps EXEC with pc_out unchanged and all control inputs ignored.
REQ-022 In EXEC with stall=0, pc_out SHALL update on that edge; the FSM then goes to HALTED if halt=1, else FETCH.
REQ-023 Next-PC priority SHALL be: trap (macro only) > jump > branch_taken > sequential.
REQ-024 Sequential: pc_plus4. Branch: pc_plus4 + (branch_offset<<2). Jump: {pc_plus4[31:28], jump_target, 2'b00}.
REQ-025 All address arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 without error.
REQ-026 imem_req and instr_valid SHALL be 0 in IDLE and HALTED; HALTED is left only by reset.
REQ-027 imem_ack SHALL be ignored outside FETCH; stall, branch, jump, halt and trap SHALL be ignored outside EXEC.
REQ-028 halt together with jump or branch in EXEC SHALL apply the redirect before entering HALTED.
REQ-029 Minimum cycles per instruction SHALL be 2 (FETCH with immediate ack, then EXEC).

Reset
REQ-030 reset=0 SHALL immediately, without waiting for clk, force IDLE, pc_out=RESET_ADDR, imem_req=0, instr_valid=0, epc=0.
REQ-031 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the operation; no PC update SHALL occur on the edge at which reset is released.

Configuration
REQ-032 Macro PC_TRAP_VECTOR_EN defined: trap port and epc port exist; in EXEC with stall=0 and trap=1, pc_out<=TRAP_ADDR, epc<=pc_out, halt ignored, next state FETCH.
REQ-033 Macro PC_TRAP_VECTOR_EN undefined: trap and epc ports are absent and no trap logic is compiled.

Verification
REQ-034 Reset release, imem_ack tied 1, no redirects -> pc_out 0,4,8,C, one instruction per 2 cycles.
REQ-035 pc_out=32'h40, branch_taken=1, branch_offset=32'hFFFF_FFFE -> pc_out=32'h3C; jump=1 simultaneously -> jump_target wins.
REQ-036 imem_ack held 0 for 3 cycles in FETCH, then stall=1 for 2 EXEC cycles -> imem_req high 4 cycles, instr_valid high 3 cycles, pc_out constant.
REQ-037 pc_out=32'hFFFF_FFFC sequential -> 32'h0000_0000; halt=1 with jump -> PC updated, HALTED, imem_req stays 0.
REQ-038 reset pulsed low mid-FETCH, then with PC_TRAP_VECTOR_EN trap=1 at pc_out=32'h10 -> pc_out=RESET_ADDR asynchronously; after trap pc_out=32'h80, epc=32'h10.
